// File: rtl/stf_generator_if.sv
// Sample-request / sample-return bundle between the preamble sequencer and the L-STF generator.
interface stf_generator_if;
   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned COEFF_W  = 24;
   localparam int unsigned SYMBOL_W = 32;

   logic [ADDR_W-1:0]   addr;
   logic [COEFF_W-1:0]  coeffs;
   logic [SYMBOL_W-1:0] symbol;

   // Sequencer side: supplies index and obfuscation codes, consumes the sample.
   modport master (output addr, output coeffs, input symbol);
   // Generator side.
   modport slave  (input addr, input coeffs, output symbol);
endinterface

// File: rtl/stf_generator.sv
// L-STF sample generator: sum of the 12 non-zero STF subcarriers at sample index addr,
// each subcarrier passed / negated / halved / nulled by its 2-bit code, registered output.
module stf_generator (
   input  logic            clk,
   input  logic            phy_tx_arestn,
   stf_generator_if.slave  bus
);
   localparam int unsigned N_SC   = 12;
   localparam int unsigned TW_W   = 12;
   localparam int unsigned TERM_W = 13;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned PH_W   = 4;

   // Subcarriers whose base STF sign is -1 (i = 1, 3, 4, 6, 7).
   localparam logic [N_SC-1:0] NEG_MASK = 12'h0DA;

   // round(1024*cos(2*pi*p/16)); sin is the same table shifted by a quarter period.
   function automatic logic signed [TW_W-1:0] twiddle(input logic [PH_W-1:0] p);
      logic signed [TW_W-1:0] v;
      case (p)
         4'd0:    v =  12'sd1024;
         4'd1:    v =  12'sd946;
         4'd2:    v =  12'sd724;
         4'd3:    v =  12'sd392;
         4'd4:    v =  12'sd0;
         4'd5:    v = -12'sd392;
         4'd6:    v = -12'sd724;
         4'd7:    v = -12'sd946;
         4'd8:    v = -12'sd1024;
         4'd9:    v = -12'sd946;
         4'd10:   v = -12'sd724;
         4'd11:   v = -12'sd392;
         4'd12:   v =  12'sd0;
         4'd13:   v =  12'sd392;
         4'd14:   v =  12'sd724;
         default: v =  12'sd946;
      endcase
      return v;
   endfunction

   // Harmonic m = k/4 for subcarrier i, expressed modulo 16.
   function automatic logic [PH_W-1:0] harmonic(input int i);
      logic [PH_W-1:0] m;
      case (i)
         0:       m = 4'd10;   // k = -24
         1:       m = 4'd11;   // k = -20
         2:       m = 4'd12;   // k = -16
         3:       m = 4'd13;   // k = -12
         4:       m = 4'd14;   // k = -8
         5:       m = 4'd15;   // k = -4
         6:       m = 4'd1;    // k = +4
         7:       m = 4'd2;    // k = +8
         8:       m = 4'd3;    // k = +12
         9:       m = 4'd4;    // k = +16
         10:      m = 4'd5;    // k = +20
         default: m = 4'd6;    // k = +24
      endcase
      return m;
   endfunction

   logic signed [TERM_W-1:0] w_re [N_SC];
   logic signed [TERM_W-1:0] w_im [N_SC];
   logic signed [OUT_W-1:0]  w_sum_i;
   logic signed [OUT_W-1:0]  w_sum_q;
   logic [31:0]              r_symbol;

   for (genvar g = 0; g < N_SC; g++) begin : g_sc
      localparam logic [PH_W-1:0] HARM = harmonic(g);

      logic [PH_W-1:0]          w_p;
      logic [1:0]               w_code;
      logic signed [TW_W-1:0]   w_c;
      logic signed [TW_W-1:0]   w_s;
      logic signed [TERM_W-1:0] w_re_raw;
      logic signed [TERM_W-1:0] w_im_raw;

      // Phase wraps naturally in 4 bits, which also handles negative harmonics.
      assign w_p    = HARM * bus.addr;
      assign w_code = bus.coeffs[2*g +: 2];
      assign w_c    = twiddle(w_p);
      assign w_s    = twiddle(w_p - 4'd4);

      // s_k*(1+j) times (C + jS): re = s_k*(C - S), im = s_k*(C + S).
      assign w_re_raw = NEG_MASK[g] ? (TERM_W'(w_s) - TERM_W'(w_c)) : (TERM_W'(w_c) - TERM_W'(w_s));
      assign w_im_raw = NEG_MASK[g] ? (-TERM_W'(w_c) - TERM_W'(w_s)) : (TERM_W'(w_c) + TERM_W'(w_s));

      // Apply the per-subcarrier obfuscation code.
      always_comb begin
         w_re[g] = w_re_raw;
         w_im[g] = w_im_raw;
         case (w_code)
            2'b01: begin
               w_re[g] = -w_re_raw;
               w_im[g] = -w_im_raw;
            end
            2'b10: begin
               w_re[g] = w_re_raw >>> 1;
               w_im[g] = w_im_raw >>> 1;
            end
            2'b11: begin
               w_re[g] = '0;
               w_im[g] = '0;
            end
            default: ;
         endcase
      end
   end

   // Accumulate all subcarrier terms; 16 bits hold the worst case exactly.
   always_comb begin
      w_sum_i = '0;
      w_sum_q = '0;
      for (int i = 0; i < N_SC; i++) begin
         w_sum_i = w_sum_i + OUT_W'(w_re[i]);
         w_sum_q = w_sum_q + OUT_W'(w_im[i]);
      end
   end

   // Output sample register, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge phy_tx_arestn) begin
      if (!phy_tx_arestn) r_symbol <= '0;
      else                r_symbol <= {w_sum_i, w_sum_q};
   end

   assign bus.symbol = r_symbol;
endmodule

// File: tb/tb_stf_generator.sv
// Directed bench for stf_generator: reset, standard STF, halving, negate/null,
// single subcarrier, periodicity/latency, coefficient change and random reference compare.
module tb_stf_generator;
   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   stf_generator_if bus ();

   stf_generator u_dut (
      .clk           (clk),
      .phy_tx_arestn (rst_n),
      .bus           (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int K_TAB [12] = '{-24, -20, -16, -12, -8, -4, 4, 8, 12, 16, 20, 24};
   localparam int S_TAB [12] = '{1, -1, 1, -1, -1, 1, -1, -1, 1, 1, 1, 1};

   function automatic int tw_cos(input int p);
      real x;
      x = 1024.0 * $cos(2.0 * 3.14159265358979 * real'(p) / 16.0);
      return int'($floor(x + 0.5));
   endfunction

   function automatic int tw_sin(input int p);
      real x;
      x = 1024.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 16.0);
      return int'($floor(x + 0.5));
   endfunction

   // Golden model straight from the subcarrier-sum equations.
   function automatic logic [31:0] model(input int n, input logic [23:0] cf);
      int acc_i, acc_q, m, p, re, im, code;
      logic [15:0] oi, oq;
      acc_i = 0;
      acc_q = 0;
      for (int i = 0; i < 12; i++) begin
         m    = K_TAB[i] / 4;
         p    = (((m * n) % 16) + 16) % 16;
         re   = S_TAB[i] * (tw_cos(p) - tw_sin(p));
         im   = S_TAB[i] * (tw_cos(p) + tw_sin(p));
         code = int'((cf >> (2 * i)) & 24'h3);
         if (code == 1) begin
            re = -re;
            im = -im;
         end else if (code == 2) begin
            re = re >>> 1;
            im = im >>> 1;
         end else if (code == 3) begin
            re = 0;
            im = 0;
         end
         acc_i += re;
         acc_q += im;
      end
      oi = 16'(acc_i);
      oq = 16'(acc_q);
      return {oi, oq};
   endfunction

   // Present one input vector at the falling edge and return #1 after the next rising edge.
   task automatic drive(input logic [3:0] a, input logic [23:0] cf);
      @(negedge clk);
      bus.addr   = a;
      bus.coeffs = cf;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      bus.addr   = 4'd5;
      bus.coeffs = 24'h123456;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (bus.symbol !== 32'h00000000) begin
         n_err++;
         $display("FAIL reset_hold got %h exp %h", bus.symbol, 32'h00000000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(4'd0, 24'h000000);
      n_vec++;
      if (bus.symbol !== 32'h08000800) begin
         n_err++;
         $display("FAIL first_sample got %h exp %h", bus.symbol, 32'h08000800);
      end
   endtask

   task automatic test_halving();
      logic [31:0] exp_v;
      drive(4'd0, 24'hAAAAAA);
      n_vec++;
      if (bus.symbol !== 32'h04000400) begin
         n_err++;
         $display("FAIL halve_addr0 got %h exp %h", bus.symbol, 32'h04000400);
      end
      for (int a = 0; a < 16; a++) begin
         drive(4'(a), 24'hAAAAAA);
         exp_v = model(a, 24'hAAAAAA);
         n_vec++;
         if (bus.symbol !== exp_v) begin
            n_err++;
            $display("FAIL halve_sweep addr=%0d got %h exp %h", a, bus.symbol, exp_v);
         end
      end
   endtask

   task automatic test_negate_null();
      drive(4'd0, 24'h555555);
      n_vec++;
      if (bus.symbol !== 32'hF800F800) begin
         n_err++;
         $display("FAIL negate_addr0 got %h exp %h", bus.symbol, 32'hF800F800);
      end
      for (int a = 0; a < 16; a++) begin
         drive(4'(a), 24'hFFFFFF);
         n_vec++;
         if (bus.symbol !== 32'h00000000) begin
            n_err++;
            $display("FAIL null addr=%0d got %h exp %h", a, bus.symbol, 32'h00000000);
         end
      end
   endtask

   task automatic test_single_subcarrier();
      logic [3:0]  addrs [3];
      logic [31:0] exps  [3];
      addrs = '{4'd0, 4'd4, 4'd8};
      exps  = '{32'hFC00FC00, 32'h0400FC00, 32'h04000400};
      for (int v = 0; v < 3; v++) begin
         drive(addrs[v], 24'hFFCFFF);
         n_vec++;
         if (bus.symbol !== exps[v]) begin
            n_err++;
            $display("FAIL single_k4 addr=%0d got %h exp %h", addrs[v], bus.symbol, exps[v]);
         end
      end
   endtask

   task automatic test_periodicity();
      logic [31:0] cap [160];
      logic [31:0] prev_exp;
      logic [31:0] exp_v;
      drive(4'd15, 24'h000000);
      prev_exp = model(15, 24'h000000);
      for (int idx = 0; idx < 160; idx++) begin
         @(negedge clk);
         bus.addr   = 4'(idx);
         bus.coeffs = 24'h000000;
         #1;
         n_vec++;
         if (bus.symbol !== prev_exp) begin
            n_err++;
            $display("FAIL latency_hold idx=%0d got %h exp %h", idx, bus.symbol, prev_exp);
         end
         @(posedge clk);
         #1;
         cap[idx] = bus.symbol;
         exp_v    = model(idx % 16, 24'h000000);
         n_vec++;
         if (bus.symbol !== exp_v) begin
            n_err++;
            $display("FAIL period_sample idx=%0d got %h exp %h", idx, bus.symbol, exp_v);
         end
         prev_exp = exp_v;
      end
      for (int idx = 16; idx < 160; idx++) begin
         n_vec++;
         if (cap[idx] !== cap[idx % 16]) begin
            n_err++;
            $display("FAIL period_repeat idx=%0d got %h exp %h", idx, cap[idx], cap[idx % 16]);
         end
      end
   endtask

   task automatic test_coeff_change();
      drive(4'd0, 24'h000000);
      @(negedge clk);
      bus.coeffs = 24'h555555;
      #1;
      n_vec++;
      if (bus.symbol !== 32'h08000800) begin
         n_err++;
         $display("FAIL coeff_no_glitch got %h exp %h", bus.symbol, 32'h08000800);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.symbol !== 32'hF800F800) begin
         n_err++;
         $display("FAIL coeff_next_edge got %h exp %h", bus.symbol, 32'hF800F800);
      end
   endtask

   task automatic test_reset_midstream();
      drive(4'd0, 24'h000000);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.symbol !== 32'h00000000) begin
         n_err++;
         $display("FAIL mid_reset_async got %h exp %h", bus.symbol, 32'h00000000);
      end
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.symbol !== 32'h00000000) begin
         n_err++;
         $display("FAIL mid_reset_hold got %h exp %h", bus.symbol, 32'h00000000);
      end
      @(negedge clk);
      rst_n      = 1'b1;
      bus.addr   = 4'd4;
      bus.coeffs = 24'hFFCFFF;
      #1;
      n_vec++;
      if (bus.symbol !== 32'h00000000) begin
         n_err++;
         $display("FAIL mid_reset_release got %h exp %h", bus.symbol, 32'h00000000);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (bus.symbol !== 32'h0400FC00) begin
         n_err++;
         $display("FAIL mid_reset_first got %h exp %h", bus.symbol, 32'h0400FC00);
      end
   endtask

   task automatic test_random();
      logic [23:0] cf;
      logic [31:0] exp_v;
      for (int r = 0; r < 24; r++) begin
         cf = 24'($urandom());
         for (int a = 0; a < 16; a++) begin
            drive(4'(a), cf);
            exp_v = model(a, cf);
            n_vec++;
            if (bus.symbol !== exp_v) begin
               n_err++;
               $display("FAIL random addr=%0d coeffs=%h got %h exp %h", a, cf, bus.symbol, exp_v);
            end
         end
      end
   endtask

   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst_n      = 1'b0;
      bus.addr   = '0;
      bus.coeffs = '0;
      test_reset();
      test_halving();
      test_negate_null();
      test_single_subcarrier();
      test_periodicity();
      test_coeff_change();
      test_reset_midstream();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
